// File: rtl/psum_pkg.sv
// Shared types and constant helpers for the partial-sum accumulator and its
// truncating saturating adder.
package psum_pkg;

    typedef enum logic {IDLE, ACCUM} state_t;

    // Results are 64 bits wide; callers slice the low ACC_WIDTH bits.
    function automatic logic [63:0] trunc_mask(input int ignore_bit);
        return ~((64'd1 << ignore_bit) - 64'd1);
    endfunction

    function automatic logic [63:0] sat_max(input int acc_width, input int ignore_bit);
        return ((64'd1 << (acc_width - 1)) - 64'd1) & trunc_mask(ignore_bit);
    endfunction

    function automatic logic [63:0] sat_min(input int acc_width, input int ignore_bit);
        return 64'd1 << (acc_width - 1);
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// Input beat stream, flush control and result handshake of the accumulator.
interface psum_accumulator_if #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 8
);
    logic                 clear;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output clear, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  clear, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/psum_sat_add.sv
// Combinational adder that zeroes the low IGNORE_BIT bits of both operands and
// clamps signed overflow to the truncated extremes.
module psum_sat_add
    import psum_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int IGNORE_BIT = 0
) (
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [ACC_WIDTH-1:0] in_ext,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 ovf
);
    localparam logic [63:0] MASK = trunc_mask(IGNORE_BIT);
    localparam logic [63:0] MAX  = sat_max(ACC_WIDTH, IGNORE_BIT);
    localparam logic [63:0] MIN  = sat_min(ACC_WIDTH, IGNORE_BIT);

    logic [ACC_WIDTH-1:0] a, b, s;

    assign a   = acc    & MASK[ACC_WIDTH-1:0];
    assign b   = in_ext & MASK[ACC_WIDTH-1:0];
    assign s   = a + b;
    assign ovf = (a[ACC_WIDTH-1] == b[ACC_WIDTH-1]) && (s[ACC_WIDTH-1] != a[ACC_WIDTH-1]);
    assign sum = !ovf ? s : (a[ACC_WIDTH-1] ? MIN[ACC_WIDTH-1:0] : MAX[ACC_WIDTH-1:0]);
endmodule

// File: rtl/psum_accumulator.sv
// Accumulates an in_last-delimited stream of signed partial sums and presents
// each saturated result through a single-entry valid/ready output register.
module psum_accumulator
    import psum_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int IGNORE_BIT = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst_n,
    psum_accumulator_if.slave io
);
    state_t               state;
    logic [ACC_WIDTH-1:0] acc, acc_op, in_ext, sum;
    logic [CNT_WIDTH-1:0] count, cnt_next;
    logic                 ovf_sticky, add_ovf, accept;

    assign io.in_ready = ~io.clear & (~io.out_valid | io.out_ready);
    assign accept      = io.in_valid & io.in_ready;
    assign in_ext      = ACC_WIDTH'($signed(io.in_data));
    // A fresh element always starts from zero, regardless of acc contents.
    assign acc_op      = (state == IDLE) ? '0 : acc;
    assign cnt_next    = (count == '1) ? count : count + 1'b1;

    psum_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .IGNORE_BIT(IGNORE_BIT)
    ) u_add (
        .acc   (acc_op),
        .in_ext(in_ext),
        .sum   (sum),
        .ovf   (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            ovf_sticky   <= 1'b0;
            io.out_valid <= 1'b0;
            io.out_data  <= '0;
            io.out_count <= '0;
            io.out_ovf   <= 1'b0;
        end else begin
            if (io.clear || (accept && io.in_last)) begin
                state      <= IDLE;
                acc        <= '0;
                count      <= '0;
                ovf_sticky <= 1'b0;
            end else if (accept) begin
                state      <= ACCUM;
                acc        <= sum;
                count      <= cnt_next;
                ovf_sticky <= ovf_sticky | add_ovf;
            end
            // accept already implies ~clear, so the output register never sees a flushed beat.
            if (accept && io.in_last) begin
                io.out_valid <= 1'b1;
                io.out_data  <= sum;
                io.out_count <= cnt_next;
                io.out_ovf   <= ovf_sticky | add_ovf;
            end else if (io.out_valid && io.out_ready) begin
                io.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_psum_accumulator.sv
// Drives three accumulator configurations (32b exact, 32b IGNORE_BIT=2, 16b exact)
// from one shared stimulus and checks each against hand-computed results.
module tb_psum_accumulator;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic signed [15:0] in_data = '0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    psum_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(8)) i0 ();
    psum_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(8)) i1 ();
    psum_accumulator_if #(.IN_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8)) i2 ();

    assign {i0.clear, i0.in_valid, i0.in_data, i0.in_last, i0.out_ready} = {clear, in_valid, in_data, in_last, out_ready};
    assign {i1.clear, i1.in_valid, i1.in_data, i1.in_last, i1.out_ready} = {clear, in_valid, in_data, in_last, out_ready};
    assign {i2.clear, i2.in_valid, i2.in_data, i2.in_last, i2.out_ready} = {clear, in_valid, in_data, in_last, out_ready};

    psum_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(32), .IGNORE_BIT(0), .CNT_WIDTH(8)) u0 (.clk(clk), .rst_n(rst_n), .io(i0));
    psum_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(32), .IGNORE_BIT(2), .CNT_WIDTH(8)) u1 (.clk(clk), .rst_n(rst_n), .io(i1));
    psum_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(16), .IGNORE_BIT(0), .CNT_WIDTH(8)) u2 (.clk(clk), .rst_n(rst_n), .io(i2));

    typedef struct {
        logic              v;
        logic signed [15:0] d;
        logic              l;
        logic              ev;
        longint            e0, e1, e2;
        int                ec;
        logic [2:0]        eo;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic signed [15:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic chk_out(input string name, input logic ev, input longint e0, input longint e1,
                           input longint e2, input int ec, input logic [2:0] eo);
        chk({name, ".valid0"}, longint'(i0.out_valid), longint'(ev));
        chk({name, ".valid1"}, longint'(i1.out_valid), longint'(ev));
        chk({name, ".valid2"}, longint'(i2.out_valid), longint'(ev));
        if (ev) begin
            chk({name, ".data0"}, longint'($signed(i0.out_data)), e0);
            chk({name, ".data1"}, longint'($signed(i1.out_data)), e1);
            chk({name, ".data2"}, longint'($signed(i2.out_data)), e2);
            chk({name, ".count"}, longint'(i0.out_count), longint'(ec));
            chk({name, ".ovf"}, longint'({i2.out_ovf, i1.out_ovf, i0.out_ovf}), longint'(eo));
        end
    endtask

    initial begin
        // v, d, l -> valid, data per config, count, ovf bits {cfg2,cfg1,cfg0}
        vecs[0]  = '{1'b1,      16'sd5, 1'b0, 1'b0,      0,      0,      0, 0, 3'b000};
        vecs[1]  = '{1'b1,     -16'sd3, 1'b0, 1'b0,      0,      0,      0, 0, 3'b000};
        vecs[2]  = '{1'b1,     16'sd10, 1'b1, 1'b1,     12,      8,     12, 3, 3'b000};
        vecs[3]  = '{1'b1,      16'sd7, 1'b0, 1'b0,      0,      0,      0, 0, 3'b000};
        vecs[4]  = '{1'b1,      16'sd6, 1'b1, 1'b1,     13,      8,     13, 2, 3'b000};
        vecs[5]  = '{1'b1,  16'sd32767, 1'b0, 1'b0,      0,      0,      0, 0, 3'b000};
        vecs[6]  = '{1'b1,      16'sd1, 1'b0, 1'b0,      0,      0,      0, 0, 3'b000};
        vecs[7]  = '{1'b1,     -16'sd5, 1'b1, 1'b1,  32763,  32756,  32762, 3, 3'b100};
        vecs[8]  = '{1'b1, -16'sd32768, 1'b0, 1'b0,      0,      0,      0, 0, 3'b000};
        vecs[9]  = '{1'b1,     -16'sd1, 1'b1, 1'b1, -32769, -32772, -32768, 2, 3'b100};
        vecs[10] = '{1'b1,      16'sd1, 1'b1, 1'b1,      1,      0,      1, 1, 3'b000};
        vecs[11] = '{1'b1,      16'sd2, 1'b1, 1'b1,      2,      0,      2, 1, 3'b000};
        vecs[12] = '{1'b1,      16'sd3, 1'b1, 1'b1,      3,      0,      3, 1, 3'b000};
        vecs[13] = '{1'b1,     -16'sd1, 1'b1, 1'b1,     -1,     -4,     -1, 1, 3'b000};
        vecs[14] = '{1'b0,      16'sd0, 1'b0, 1'b0,      0,      0,      0, 0, 3'b000};

        #12;
        chk_out("reset", 1'b0, 0, 0, 0, 0, 3'b000);
        chk("reset.data0", longint'(i0.out_data), 0);
        chk("reset.count0", longint'(i0.out_count), 0);
        chk("reset.ovf0", longint'(i0.out_ovf), 0);
        tick();
        rst_n = 1'b1;
        chk("reset.in_ready", longint'(i0.in_ready), 1);
        out_ready = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].l);
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].ec, vecs[i].eo);
        end

        // Backpressure: result held, input stalled, stalled beat taken on release.
        out_ready = 1'b0;
        drive(1'b1, 16'sd20, 1'b1);
        tick();
        chk_out("bp.emit", 1'b1, 20, 20, 20, 1, 3'b000);
        drive(1'b1, 16'sd7, 1'b1);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("bp.in_ready%0d", c), longint'(i0.in_ready), 0);
            tick();
            chk_out($sformatf("bp.hold%0d", c), 1'b1, 20, 20, 20, 1, 3'b000);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready_rel", longint'(i0.in_ready), 1);
        tick();
        chk_out("bp.reload", 1'b1, 7, 4, 7, 1, 3'b000);
        drive(1'b0, 16'sd0, 1'b0);
        tick();
        chk_out("bp.drain", 1'b0, 0, 0, 0, 0, 3'b000);

        // Beat counter saturates at 255 over a 300-beat element.
        for (int c = 0; c < 299; c++) begin
            drive(1'b1, 16'sd1, 1'b0);
            tick();
        end
        drive(1'b1, 16'sd1, 1'b1);
        tick();
        chk_out("cnt_sat", 1'b1, 300, 0, 300, 255, 3'b000);

        // in_last without in_valid is ignored.
        drive(1'b1, 16'sd2, 1'b0);
        tick();
        drive(1'b0, 16'sd0, 1'b1);
        tick();
        chk_out("last_novalid", 1'b0, 0, 0, 0, 0, 3'b000);
        drive(1'b1, 16'sd4, 1'b1);
        tick();
        chk_out("last_after", 1'b1, 6, 4, 6, 2, 3'b000);

        // clear flushes the element, blocks the same-cycle beat, spares a pending result.
        drive(1'b1, 16'sd100, 1'b0);
        tick();
        drive(1'b1, 16'sd200, 1'b0);
        tick();
        clear = 1'b1;
        drive(1'b1, 16'sd50, 1'b0);
        #1;
        chk("clr.in_ready", longint'(i0.in_ready), 0);
        tick();
        clear = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 16'sd9, 1'b1);
        tick();
        chk_out("clr.after", 1'b1, 9, 8, 9, 1, 3'b000);
        clear = 1'b1;
        drive(1'b0, 16'sd0, 1'b0);
        tick();
        chk_out("clr.pending", 1'b1, 9, 8, 9, 1, 3'b000);
        out_ready = 1'b1;
        tick();
        chk_out("clr.handshake", 1'b0, 0, 0, 0, 0, 3'b000);
        clear = 1'b0;

        // Asynchronous reset during a held result and mid-element.
        drive(1'b1, 16'sd11, 1'b0);
        tick();
        out_ready = 1'b0;
        drive(1'b1, 16'sd22, 1'b1);
        tick();
        chk_out("rst.hold", 1'b1, 33, 28, 33, 2, 3'b000);
        drive(1'b0, 16'sd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.hold.valid", longint'(i0.out_valid), 0);
        chk("rst.hold.data", longint'(i0.out_data), 0);
        chk("rst.hold.count", longint'(i0.out_count), 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'sd11, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.mid.valid", longint'(i0.out_valid), 0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 16'sd5, 1'b1);
        tick();
        chk_out("rst.after", 1'b1, 5, 4, 5, 1, 3'b000);
        drive(1'b0, 16'sd0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream consumer of the truncated signed adder stage in the systolic-array PE column.
- Accumulates a stream of signed partial sums over one output element, delimited by in_last.
- Applies the same LSB-ignore truncation as the adder, saturates at ACC_WIDTH, and presents the result through a single-entry valid/ready output register to the drain path.

Parameters:
- IN_WIDTH, 16: width of the signed input partial sum (adder OUT width).
- ACC_WIDTH, 32: width of the signed accumulator and result; must be >= IN_WIDTH.
- IGNORE_BIT, 0: number of LSBs forced to zero on both operands before the add; 0 gives exact arithmetic.
- CNT_WIDTH, 8: width of the beat counter reported with each result.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous flush of the in-progress accumulation.
- in_valid  input  1  in_data/in_last valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_data  input  IN_WIDTH  signed partial sum.
- in_last  input  1  final beat of the current element.
- out_valid  output  1  result held in the output register.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_WIDTH  signed accumulated result.
- out_count  output  CNT_WIDTH  number of beats in the result.
- out_ovf  output  1  saturation occurred during this element.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE; acc, count and ovf_sticky = 0; out_valid=0; out_data=0; out_count=0; out_ovf=0.
- Accept condition: accept = in_valid & in_ready.
- in_ready = ~clear & (~out_valid | out_ready). This allows zero-bubble operation while draining.
- State IDLE: acc == 0, no beats yet.
  - accept & ~in_last goes to ACCUM.
  - accept & in_last emits a single-beat result and stays in IDLE.
- State ACCUM: one or more beats collected.
  - accept & in_last emits the result and goes to IDLE.
  - clear goes to IDLE.
- Arithmetic: in_ext = sign-extend(in_data) to ACC_WIDTH. Both acc and in_ext have bits [IGNORE_BIT-1:0] zeroed, then are added.
  - Signed overflow is detected when both operands have the same sign and the sum sign differs.
  - On overflow, clamp to +2^(ACC_WIDTH-1)-1 or -2^(ACC_WIDTH-1) with the low IGNORE_BIT bits zeroed, and set ovf_sticky.
  - Once saturated, later beats still add normally from the clamped value.
- Beat counter: count increments per accepted beat and saturates at 2^CNT_WIDTH-1; it does not wrap.
- Emit: in the cycle after the in_last accept, out_valid=1 and:
  - out_data = final saturated sum.
  - out_count = count + 1 (saturated).
  - out_ovf = ovf_sticky | overflow on this beat.
  - acc, count and ovf_sticky return to 0 in the same edge.
- Latency: 1 cycle from the last beat accepted to out_valid.
- Output hold: out_valid, out_data, out_count and out_ovf hold stable until out_valid & out_ready.
  - If a new emit coincides with the handshake, the register reloads and out_valid stays 1.
  - Otherwise out_valid falls to 0 on the handshake.
- Backpressure: when out_valid=1 and out_ready=0, in_ready=0. No beat is lost and acc is frozen.
- clear: has priority over in_valid. It forces in_ready=0, zeroes acc, count and ovf_sticky, and sets state=IDLE. It does not touch a pending out_valid result.
- clear in the same cycle as out_ready: the output handshake still completes.
- in_last with in_valid=0 is ignored.
- Asynchronous reset mid-element or mid-hold: all state is discarded immediately, and out_valid drops without a handshake.

Decomposition:
- Shared package psum_pkg holds:
  - state enum {IDLE, ACCUM}.
  - functions sat_max(ACC_WIDTH, IGNORE_BIT) and sat_min(ACC_WIDTH, IGNORE_BIT).
  - a function for the truncation mask.
- One natural sub-module, psum_sat_add: combinational truncating saturating adder.
  - Inputs: acc, in_ext.
  - Outputs: sum, ovf.
  - Parameters: ACC_WIDTH, IGNORE_BIT.
  - It is reusable wherever the truncated adder needs overflow protection.
- The FSM, counter and output register stay in psum_accumulator.

Test Plan:
- Basic sum, IGNORE_BIT=0: beats 5, -3, 10 (last), out_ready=1. Expect out_valid one cycle after the last beat, out_data=12, out_count=3, out_ovf=0.
- Truncation, IGNORE_BIT=2: beats 7, 6 (last). Expect out_data=4+4=8.
- Saturation, ACC_WIDTH=16, IN_WIDTH=16:
  - beats 32767, 1, -5 (last) -> out_data=32762, out_ovf=1.
  - beats -32768, -1 (last) -> out_data=-32768, out_ovf=1.
- Backpressure: emit with out_ready=0 for 4 cycles while in_valid=1.
  - Expect in_ready=0 and outputs stable for 4 cycles.
  - On out_ready=1, that same-cycle beat is accepted.
  - Back-to-back single-beat elements 1, 2, 3 with out_ready=1 give results 1, 2, 3 on consecutive cycles.
- clear: beats 100, 200, then clear with in_valid=1 and in_data=50. Expect the 50 is not accepted (in_ready=0). A following 9 (last) gives out_data=9, out_count=1. Pending output is unaffected by clear.
- Reset: assert rst_n=0 mid-element and with out_valid=1 (async, off-edge). Expect out_valid=0 immediately and all outputs 0. The first element after release sums from 0.
